led_mode_controller: RTL

LED_MODE_CONTROLLER -- requirements
Module: led_mode_controller

---
 rtl/led_mode_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/led_mode_controller.sv
// LED mode controller: debounced mode button steps MIRROR/BLINK/SHIFT/COUNT,
// a free-running tick divider paces the animated modes, LEDs are registered.
module led_mode_controller #(
  parameter int TICK_DIV     = 50000000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  input  logic        btn_mode,
  output logic [15:0] led,
  output logic [1:0]  mode
);

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW  = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MIRROR = 2'd0,
    BLINK  = 2'd1,
    SHIFT  = 2'd2,
    COUNT  = 2'd3
  } mode_e;

  logic           sync1_q, sync2_q;
  logic           db_q, db_d, db_prev_q;
  logic [DBW-1:0] dbc_q, dbc_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  mode_e          mode_q, mode_d;
  logic           phase_q, phase_d;
  logic [15:0]    pattern_q, pattern_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [15:0]    led_q, led_d;
  logic           adv;
  logic           tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_q       <= 1'b0;
      db_prev_q  <= 1'b0;
      dbc_q      <= '0;
      tick_cnt_q <= '0;
      mode_q     <= MIRROR;
      phase_q    <= 1'b1;
      pattern_q  <= 16'h0000;
      cnt_q      <= 16'h0000;
      led_q      <= 16'h0000;
    end else begin
      sync1_q    <= btn_mode;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      dbc_q      <= dbc_d;
      tick_cnt_q <= tick_cnt_d;
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      pattern_q  <= pattern_d;
      cnt_q      <= cnt_d;
      led_q      <= led_d;
    end
  end

  // Counter only runs while the synced level disagrees with the debounced one.
  always_comb begin
    db_d  = db_q;
    dbc_d = '0;
    if (sync2_q != db_q) begin
      if (dbc_q == DB_LAST) begin
        db_d = ~db_q;
      end else begin
        dbc_d = dbc_q + 1'b1;
      end
    end
  end

  assign adv  = db_q & ~db_prev_q;
  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    mode_d = mode_q;
    if (adv) begin
      case (mode_q)
        MIRROR:  mode_d = BLINK;
        BLINK:   mode_d = SHIFT;
        SHIFT:   mode_d = COUNT;
        default: mode_d = MIRROR;
      endcase
    end
  end

  // A mode change restarts the divider and swallows any coincident tick.
  always_comb begin
    tick_cnt_d = (adv || tick) ? '0 : tick_cnt_q + 1'b1;
    phase_d    = phase_q;
    pattern_d  = pattern_q;
    cnt_d      = cnt_q;
    if (adv) begin
      case (mode_d)
        BLINK:   phase_d   = 1'b1;
        SHIFT:   pattern_d = (sw == 16'h0000) ? 16'h0001 : sw;
        COUNT:   cnt_d     = 16'h0000;
        default: ;
      endcase
    end else if (tick) begin
      case (mode_q)
        BLINK:   phase_d   = ~phase_q;
        SHIFT:   pattern_d = {pattern_q[14:0], pattern_q[15]};
        COUNT:   cnt_d     = cnt_q + 16'h0001;
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d = 16'h0000;
    case (mode_q)
      MIRROR:  led_d = sw;
      BLINK:   led_d = phase_q ? sw : 16'h0000;
      SHIFT:   led_d = pattern_q;
      default: led_d = cnt_q;
    endcase
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule
